iq_delay_comp: RTL and testbench

//   Programmable, sample-counted I/Q delay compensator for one beamformer channel.

---
 rtl/beamform_pkg.sv | 12 +
 rtl/iq_ring_ram.sv | 24 ++
 rtl/iq_delay_comp.sv | 94 +++++++++
 tb/tb_iq_delay_comp.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/beamform_pkg.sv
// Shared beamformer types and defaults used by the per-channel alignment blocks.
package beamform_pkg;

  localparam int IQ_DW               = 18;
  localparam int DEFAULT_ALIGN_DELAY = 3;

  typedef struct packed {
    logic signed [IQ_DW-1:0] i;
    logic signed [IQ_DW-1:0] q;
  } iq_sample_t;

endpackage

// File: rtl/iq_ring_ram.sv
// Ring storage for I/Q pairs: one synchronous write port, one asynchronous read port.
module iq_ring_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 36,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Asynchronous read returns the old contents when raddr == waddr.
  assign rdata = mem[raddr];

endmodule

// File: rtl/iq_delay_comp.sv
// Runtime-programmable I/Q delay counted in valid samples, with zero-fill priming
// after reset or a delay reload, so every channel reaches the combiner aligned.
module iq_delay_comp
  import beamform_pkg::*;
#(
  parameter int  DW            = IQ_DW,
  parameter int  MAX_DELAY     = 16,
  parameter int  DEFAULT_DELAY = DEFAULT_ALIGN_DELAY,
  localparam int AW            = $clog2(MAX_DELAY)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  input  logic signed [DW-1:0] dinI,
  input  logic signed [DW-1:0] dinQ,
  input  logic                 delay_load,
  input  logic        [AW-1:0] delay_in,
  output logic                 dout_valid,
  output logic signed [DW-1:0] doutI,
  output logic signed [DW-1:0] doutQ,
  output logic                 filled
);

  function automatic logic [AW-1:0] clamp_delay(input logic [AW-1:0] req);
    if ({1'b0, req} > (AW+1)'(MAX_DELAY - 1)) return AW'(MAX_DELAY - 1);
    return req;
  endfunction

  logic [AW-1:0]        wr_ptr, wr_next, rd_ptr;
  logic [AW-1:0]        d_reg, d_eff;
  logic [AW-1:0]        fill_cnt, fill_eff, fill_next;
  logic                 priming;
  logic [2*DW-1:0]      rd_data;
  logic signed [DW-1:0] out_i, out_q;

  iq_ring_ram #(
    .DEPTH (MAX_DELAY),
    .W     (2*DW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (din_valid),
    .waddr (wr_ptr),
    .wdata ({dinI, dinQ}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // A load takes effect for a coincident sample, which becomes sample 1 of the new fill.
  always_comb begin
    d_eff     = delay_load ? clamp_delay(delay_in) : d_reg;
    fill_eff  = delay_load ? '0 : fill_cnt;
    priming   = (fill_eff < d_eff);
    fill_next = priming ? fill_eff + AW'(1) : fill_eff;
    wr_next   = (wr_ptr == AW'(MAX_DELAY - 1)) ? '0 : wr_ptr + AW'(1);
    rd_ptr    = (wr_ptr >= d_eff) ? (wr_ptr - d_eff)
                                  : AW'({1'b0, wr_ptr} + (AW+1)'(MAX_DELAY) - {1'b0, d_eff});
    out_i     = '0;
    out_q     = '0;
    // D=0 aliases the slot being written, so bypass the RAM with the live sample.
    if (!priming && d_eff == '0) begin
      out_i = dinI;
      out_q = dinQ;
    end else if (!priming) begin
      out_i = rd_data[2*DW-1:DW];
      out_q = rd_data[DW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      d_reg      <= AW'(DEFAULT_DELAY);
      dout_valid <= 1'b0;
      doutI      <= '0;
      doutQ      <= '0;
      filled     <= 1'b0;
    end else begin
      d_reg      <= d_eff;
      dout_valid <= din_valid;
      filled     <= !delay_load && (fill_cnt == d_reg);
      if (din_valid) begin
        wr_ptr   <= wr_next;
        fill_cnt <= fill_next;
        doutI    <= out_i;
        doutQ    <= out_q;
      end else begin
        fill_cnt <= fill_eff;
      end
    end
  end

endmodule

// File: tb/tb_iq_delay_comp.sv
// Bench for iq_delay_comp: vector table plus hand-written multi-cycle sequences.
module tb_iq_delay_comp;
  import beamform_pkg::*;

  localparam int DW        = IQ_DW;
  localparam int MAX_DELAY = 16;
  localparam int AW        = $clog2(MAX_DELAY);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 din_valid;
  logic signed [DW-1:0] dinI, dinQ;
  logic                 delay_load;
  logic        [AW-1:0] delay_in;
  logic                 dout_valid;
  logic signed [DW-1:0] doutI, doutQ;
  logic                 filled;

  always #5 clk = ~clk;

  iq_delay_comp #(.DW(DW), .MAX_DELAY(MAX_DELAY), .DEFAULT_DELAY(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .dinI       (dinI),
    .dinQ       (dinQ),
    .delay_load (delay_load),
    .delay_in   (delay_in),
    .dout_valid (dout_valid),
    .doutI      (doutI),
    .doutQ      (doutQ),
    .filled     (filled)
  );

  typedef struct {
    logic v; logic ld; int dly; int i; int q;
    logic ev; int ei; int eq; int ef;
  } vec_t;

  typedef struct {
    logic ev; int ei; int eq; int ef; string tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  function automatic vec_t mk(logic v, logic ld, int dly, int i, int q,
                              logic ev, int ei, int eq, int ef);
    vec_t r;
    r.v = v; r.ld = ld; r.dly = dly; r.i = i; r.q = q;
    r.ev = ev; r.ei = ei; r.eq = eq; r.ef = ef;
    return r;
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // ef < 0 means filled is not checked on this step.
  task automatic step(input logic v, input int i, input int q, input logic ld,
                      input int dly, input logic ev, input int ei, input int eq,
                      input int ef, input string tag);
    exp_t e;
    din_valid  = v;
    dinI       = DW'(i);
    dinQ       = DW'(q);
    delay_load = ld;
    delay_in   = AW'(dly);
    e.ev = ev; e.ei = ei; e.eq = eq; e.ef = ef; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    delay_load = 1'b0;
    e = sb.pop_front();
    chk({e.tag, ".valid"}, dout_valid, e.ev);
    chk({e.tag, ".I"}, doutI, e.ei);
    chk({e.tag, ".Q"}, doutQ, e.eq);
    if (e.ef >= 0) chk({e.tag, ".filled"}, filled, e.ef);
  endtask

  initial begin
    int ex;
    rst = 1'b1; din_valid = 1'b0; dinI = '0; dinQ = '0;
    delay_load = 1'b0; delay_in = '0;

    // Default delay 3: samples 1..5
    tbl.push_back(mk(1, 0, 0, 1, -1, 1, 0,  0, 0));
    tbl.push_back(mk(1, 0, 0, 2, -2, 1, 0,  0, 0));
    tbl.push_back(mk(1, 0, 0, 3, -3, 1, 0,  0, 0));
    tbl.push_back(mk(1, 0, 0, 4, -4, 1, 1, -1, 1));
    tbl.push_back(mk(1, 0, 0, 5, -5, 1, 2, -2, 1));
    // Load D=0, then 7,8, then an idle cycle that must hold the output
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 2, -2, 0));
    tbl.push_back(mk(1, 0, 0, 7, -7, 1, 7, -7, 1));
    tbl.push_back(mk(1, 0, 0, 8, -8, 1, 8, -8, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 8, -8, 1));
    // Load D=3 and fill it
    tbl.push_back(mk(0, 1, 3, 0,  0, 0, 8, -8, 0));
    tbl.push_back(mk(1, 0, 0, 41, -41, 1, 0,   0, 0));
    tbl.push_back(mk(1, 0, 0, 42, -42, 1, 0,   0, 0));
    tbl.push_back(mk(1, 0, 0, 43, -43, 1, 0,   0, 0));
    tbl.push_back(mk(1, 0, 0, 44, -44, 1, 41, -41, 1));
    // Reload D=2 coincident with sample 50
    tbl.push_back(mk(1, 1, 2, 50, -50, 1, 0,   0, 0));
    tbl.push_back(mk(1, 0, 0, 51, -51, 1, 0,   0, 0));
    tbl.push_back(mk(1, 0, 0, 52, -52, 1, 50, -50, 1));
    // Reload D=0 coincident with sample 60: passes straight through
    tbl.push_back(mk(1, 1, 0, 60, -60, 1, 60, -60, 0));
    tbl.push_back(mk(1, 0, 0, 61, -61, 1, 61, -61, 1));

    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", dout_valid, 0);
    chk("reset.I", doutI, 0);
    chk("reset.Q", doutQ, 0);
    chk("reset.filled", filled, 0);
    rst = 1'b0;

    for (int n = 0; n < tbl.size(); n++)
      step(tbl[n].v, tbl[n].i, tbl[n].q, tbl[n].ld, tbl[n].dly,
           tbl[n].ev, tbl[n].ei, tbl[n].eq, tbl[n].ef, $sformatf("vec%0d", n));

    // D=5 with samples on alternate clocks
    step(0, 0, 0, 1, 5, 0, 61, -61, 0, "alt.load");
    for (int k = 0; k < 11; k++) begin
      ex = (k < 5) ? 0 : 10 + k - 5;
      step(1, 10 + k, -(10 + k), 0, 0, 1, ex, -ex, -1, $sformatf("alt.s%0d", k));
      step(0, 0, 0, 0, 0, 0, ex, -ex, -1, $sformatf("alt.g%0d", k));
    end
    step(0, 0, 0, 0, 0, 0, 15, -15, 1, "alt.end");

    // D=15: pointer wrap and read-before-write
    step(0, 0, 0, 1, 15, 0, 15, -15, 0, "max.load");
    for (int n = 1; n <= 40; n++) begin
      ex = (n > 15) ? n - 15 : 0;
      step(1, n, -n, 0, 0, 1, ex, -ex, (n >= 16) ? 1 : 0, $sformatf("max.n%0d", n));
    end

    // D=4 stream, then asynchronous reset between clock edges
    step(0, 0, 0, 1, 4, 0, 25, -25, 0, "rst.load");
    for (int k = 0; k < 8; k++) begin
      ex = (k >= 4) ? 196 + k : 0;
      step(1, 200 + k, -(200 + k), 0, 0, 1, ex, -ex, -1, $sformatf("rst.s%0d", k));
    end
    din_valid = 1'b1; dinI = DW'(999); dinQ = DW'(-999);
    #2 rst = 1'b1;
    #1;
    chk("async.valid", dout_valid, 0);
    chk("async.I", doutI, 0);
    chk("async.Q", doutQ, 0);
    chk("async.filled", filled, 0);
    din_valid = 1'b0;
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ex = (k >= 3) ? 100 + k - 3 : 0;
      step(1, 100 + k, -(100 + k), 0, 0, 1, ex, -ex, (k >= 3) ? 1 : 0,
           $sformatf("post.s%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
